// File: rtl/agc_ema_loop.sv
// Closed-loop AGC for complex baseband: gains I/Q, smooths the output magnitude
// with a first-order EMA and steers a saturating gain register toward a reference.
module agc_ema_loop #(
    parameter int W_IN      = 16,
    parameter int W_OUT     = 16,
    parameter int W_ALPHA   = 16,
    parameter int F_ALPHA   = 14,
    parameter int W_REF     = 16,
    parameter int F_REF     = 14,
    parameter int W_A       = 16,
    parameter int F_A       = 14,
    parameter int W_GAIN    = 18,
    parameter int F_GAIN    = 12,
    parameter int GAIN_INIT = 4096,
    parameter int MAG_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W_ALPHA-1:0]       i_alpha,
    input  logic [W_REF-1:0]         i_reference,
    input  logic [W_A-1:0]           i_a,
    input  logic                     i_freeze,
    input  logic signed [W_IN-1:0]   s_chans_dataI,
    input  logic signed [W_IN-1:0]   s_chans_dataQ,
    input  logic                     s_chans_valid,
    output logic signed [W_OUT-1:0]  m_chans_dataI,
    output logic signed [W_OUT-1:0]  m_chans_dataQ,
    output logic                     m_chans_valid,
    output logic [W_GAIN-1:0]        m_gain,
    output logic [W_REF-1:0]         m_mag_avg
);

    localparam int MAG_W  = W_IN + 1;
    localparam int MAG_F  = W_IN - 1;
    localparam int SHL    = (F_REF > MAG_F) ? F_REF - MAG_F : 0;
    localparam int SHR    = (MAG_F > F_REF) ? MAG_F - F_REF : 0;
    localparam int MAGA_W = MAG_W + SHL;
    localparam int PX_W   = W_IN + W_GAIN + 1;
    localparam int PM_W   = MAGA_W + W_GAIN;
    localparam int D_W    = W_REF + 1;
    localparam int PE_W   = W_A + D_W + 1;
    localparam int PG_W   = W_ALPHA + D_W + 1;
    localparam int GS_W   = ((PG_W > W_GAIN + 1) ? PG_W : W_GAIN + 1) + 1;
    localparam int G_SH   = F_ALPHA + F_REF - F_GAIN;

    localparam logic signed [PX_W-1:0] Y_MAX = PX_W'((longint'(1) <<< (W_OUT - 1)) - 1);
    localparam logic signed [PX_W-1:0] Y_MIN = -Y_MAX - PX_W'(1);
    localparam logic signed [PX_W-1:0] Y_RND = PX_W'(longint'(1) <<< (F_GAIN - 1));
    localparam logic [W_REF-1:0]       REF_MAX  = '1;
    localparam logic [W_GAIN-1:0]      GAIN_MAX = '1;

    // Saturating absolute value: the most negative code maps to the largest positive one.
    function automatic logic [W_IN-1:0] sat_abs(input logic signed [W_IN-1:0] x);
        if (!x[W_IN-1]) begin
            return x;
        end else if (x[W_IN-2:0] == '0) begin
            return {1'b0, {(W_IN - 1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    logic                    s1_vld_q;
    logic                    s2_vld_q;
    logic                    s3_vld_q;
    logic                    s4_vld_q;
    logic [2*W_IN-1:0]       abs_bus;
    logic [2*W_OUT-1:0]      y_bus;
    logic [W_GAIN-1:0]       gain_d, gain_q;
    logic [W_REF-1:0]        ema_d, ema_q;
    logic [W_REF-1:0]        mag_out_d, mag_out_q;
    logic [MAGA_W-1:0]       s2_mag_q;

    // Valid bits shift every cycle; data stages load only on their own valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s4_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s_chans_valid;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s4_vld_q <= s3_vld_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic signed [W_IN-1:0]  x_in;
            logic signed [W_IN-1:0]  s1_x_q;
            logic signed [W_IN-1:0]  s2_x_q;
            logic [W_IN-1:0]         s1_abs_q;
            logic signed [PX_W-1:0]  px;
            logic signed [PX_W-1:0]  px_sh;
            logic signed [W_OUT-1:0] y_d, y_q;

            assign x_in = (gi == 0) ? s_chans_dataI : s_chans_dataQ;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_x_q   <= '0;
                    s1_abs_q <= '0;
                    s2_x_q   <= '0;
                    y_q      <= '0;
                end else begin
                    if (s_chans_valid) begin
                        s1_x_q   <= x_in;
                        s1_abs_q <= sat_abs(x_in);
                    end
                    if (s1_vld_q) begin
                        s2_x_q <= s1_x_q;
                    end
                    if (s2_vld_q) begin
                        y_q <= y_d;
                    end
                end
            end

            // Half-up rounding: add half an LSB before the floor shift.
            always_comb begin
                px    = PX_W'(s2_x_q) * PX_W'($signed({1'b0, gain_q}));
                px_sh = (px + Y_RND) >>> F_GAIN;
                if (px_sh > Y_MAX) begin
                    y_d = W_OUT'(Y_MAX);
                end else if (px_sh < Y_MIN) begin
                    y_d = W_OUT'(Y_MIN);
                end else begin
                    y_d = W_OUT'(px_sh);
                end
            end

            assign abs_bus[gi*W_IN +: W_IN]   = s1_abs_q;
            assign y_bus[gi*W_OUT +: W_OUT]   = y_q;
        end
    endgenerate

    logic [MAG_W-1:0]  abs_a, abs_b, abs_max, abs_min, mag_raw;
    logic [MAGA_W-1:0] mag_al;

    always_comb begin
        abs_a   = MAG_W'(abs_bus[W_IN-1:0]);
        abs_b   = MAG_W'(abs_bus[2*W_IN-1:W_IN]);
        abs_max = (abs_a >= abs_b) ? abs_a : abs_b;
        abs_min = (abs_a >= abs_b) ? abs_b : abs_a;
        if (MAG_MODE == 1) begin
            mag_raw = abs_max + (abs_min >> 1);
        end else begin
            mag_raw = abs_a + abs_b;
        end
        mag_al = (MAGA_W'(mag_raw) << SHL) >> SHR;
    end

    logic [PM_W-1:0] pm, pm_sh;

    always_comb begin
        pm        = PM_W'(s2_mag_q) * PM_W'(gain_q);
        pm_sh     = pm >> F_GAIN;
        mag_out_d = (pm_sh > PM_W'(REF_MAX)) ? REF_MAX : W_REF'(pm_sh);
    end

    logic signed [D_W-1:0]  ema_diff;
    logic signed [PE_W-1:0] ema_prod, ema_sum;

    always_comb begin
        ema_diff = $signed(D_W'(mag_out_q)) - $signed(D_W'(ema_q));
        ema_prod = PE_W'($signed({1'b0, i_a})) * PE_W'(ema_diff);
        ema_sum  = (ema_prod >>> F_A) + $signed(PE_W'(ema_q));
        if (ema_sum[PE_W-1]) begin
            ema_d = '0;
        end else if (ema_sum > $signed(PE_W'(REF_MAX))) begin
            ema_d = REF_MAX;
        end else begin
            ema_d = W_REF'(ema_sum);
        end
    end

    logic signed [D_W-1:0]  err;
    logic signed [PG_W-1:0] g_prod;
    logic signed [GS_W-1:0] g_sum;

    // Gain step uses the EMA value just written by the preceding stage.
    always_comb begin
        err    = $signed(D_W'(i_reference)) - $signed(D_W'(ema_q));
        g_prod = PG_W'($signed({1'b0, i_alpha})) * PG_W'(err);
        g_sum  = GS_W'(g_prod >>> G_SH) + $signed(GS_W'(gain_q));
        if (g_sum[GS_W-1]) begin
            gain_d = '0;
        end else if (g_sum > $signed(GS_W'(GAIN_MAX))) begin
            gain_d = GAIN_MAX;
        end else begin
            gain_d = W_GAIN'(g_sum);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_mag_q  <= '0;
            mag_out_q <= '0;
            ema_q     <= '0;
            gain_q    <= W_GAIN'(GAIN_INIT);
        end else begin
            if (s1_vld_q) begin
                s2_mag_q <= mag_al;
            end
            if (s2_vld_q) begin
                mag_out_q <= mag_out_d;
            end
            if (s3_vld_q) begin
                ema_q <= ema_d;
            end
            if (s4_vld_q && !i_freeze) begin
                gain_q <= gain_d;
            end
        end
    end

    assign m_chans_dataI = y_bus[W_OUT-1:0];
    assign m_chans_dataQ = y_bus[2*W_OUT-1:W_OUT];
    assign m_chans_valid = s3_vld_q;
    assign m_gain        = gain_q;
    assign m_mag_avg     = ema_q;

endmodule

// File: tb/tb_agc_ema_loop.sv
// Directed bench for agc_ema_loop: reset, pass-through, abs edge, valid gaps,
// loop convergence, gain saturation and reset with samples in flight.
module tb_agc_ema_loop;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [15:0]        alpha;
    logic [15:0]        ref_v;
    logic [15:0]        a_coef;
    logic               freeze;
    logic signed [15:0] in_i, in_q;
    logic               in_vld;
    logic signed [15:0] out_i, out_q;
    logic               out_vld;
    logic [17:0]        gain;
    logic [15:0]        mag_avg;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    agc_ema_loop dut (
        .clk           (clk),
        .reset         (reset),
        .i_alpha       (alpha),
        .i_reference   (ref_v),
        .i_a           (a_coef),
        .i_freeze      (freeze),
        .s_chans_dataI (in_i),
        .s_chans_dataQ (in_q),
        .s_chans_valid (in_vld),
        .m_chans_dataI (out_i),
        .m_chans_dataQ (out_q),
        .m_chans_valid (out_vld),
        .m_gain        (gain),
        .m_mag_avg     (mag_avg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i_val, input int q_val);
        in_i   = 16'(i_val);
        in_q   = 16'(q_val);
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
    endtask

    initial begin
        logic   vld_exp;
        logic   mono;
        logic   seen;
        int     k;
        longint prev;
        longint peak;

        alpha  = '0;
        ref_v  = '0;
        a_coef = 16'd16384;
        freeze = 1'b1;
        in_i   = '0;
        in_q   = '0;
        in_vld = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_gain", gain, 4096);
        chk("reset_valid", out_vld, 0);
        chk("reset_dataI", out_i, 0);
        chk("reset_mag_avg", mag_avg, 0);
        $display("txn reset_release gain=%0d valid=%0d", gain, out_vld);

        // Unity pass-through with the loop frozen.
        send(8192, -8192);
        chk("unity_valid_n1", out_vld, 0);
        step();
        chk("unity_valid_n2", out_vld, 0);
        step();
        chk("unity_valid_n3", out_vld, 1);
        chk("unity_dataI", out_i, 8192);
        chk("unity_dataQ", out_q, -8192);
        step();
        chk("unity_valid_n4", out_vld, 0);
        chk("unity_mag_avg", mag_avg, 8192);
        step();
        chk("unity_gain", gain, 4096);
        $display("txn unity I=%0d Q=%0d mag_avg=%0d gain=%0d", out_i, out_q, mag_avg, gain);

        // Most negative inputs: abs saturates to 32767.
        send(-32768, -32768);
        step();
        step();
        chk("abs_valid", out_vld, 1);
        chk("abs_dataI", out_i, -32768);
        chk("abs_dataQ", out_q, -32768);
        step();
        chk("abs_mag_avg", mag_avg, 32767);
        step();
        chk("abs_gain", gain, 4096);
        $display("txn abs_edge I=%0d Q=%0d mag_avg=%0d", out_i, out_q, mag_avg);

        // Strobe every third cycle; outputs appear 3 cycles later and hold.
        for (int c = 0; c < 12; c++) begin
            if ((c % 3 == 0) && (c < 9)) begin
                in_i   = 16'(1000 * (c / 3 + 1));
                in_q   = -in_i;
                in_vld = 1'b1;
            end else begin
                in_vld = 1'b0;
            end
            step();
            vld_exp = (c + 1 >= 3) && ((c + 1 - 3) % 3 == 0) && (c + 1 - 3 <= 6);
            chk($sformatf("gap_valid_c%0d", c + 1), out_vld, vld_exp);
            if (c + 1 >= 3) begin
                k = (c + 1 - 3) / 3;
                if (k > 2) k = 2;
                chk($sformatf("gap_dataI_c%0d", c + 1), out_i, 1000 * (k + 1));
                chk($sformatf("gap_dataQ_c%0d", c + 1), out_q, -1000 * (k + 1));
            end
            $display("txn gap cycle=%0d valid=%0d I=%0d Q=%0d", c + 1, out_vld, out_i, out_q);
        end
        in_vld = 1'b0;

        // Closed-loop convergence to 0.5 output magnitude (gain -> 4.0).
        ref_v  = 16'd8192;
        alpha  = 16'd32768;
        step();
        freeze = 1'b0;
        prev = gain;
        peak = gain;
        mono = 1'b1;
        for (int s = 0; s < 80; s++) begin
            send(4096, 0);
            repeat (5) step();
            if (gain < prev) mono = 1'b0;
            if (gain > peak) peak = gain;
            prev = gain;
        end
        chk("conv_monotonic", mono, 1);
        chk_rng("conv_peak", peak, 4096, 16711);
        chk_rng("conv_gain", gain, 16376, 16392);
        chk_rng("conv_dataI", out_i, 16380, 16388);
        chk_rng("conv_mag_avg", mag_avg, 8188, 8196);
        $display("txn converge gain=%0d I=%0d mag_avg=%0d", gain, out_i, mag_avg);

        // Gain runs up to full scale and must stick there.
        freeze = 1'b1;
        ref_v  = 16'hFFFF;
        alpha  = 16'hFFFF;
        step();
        freeze = 1'b0;
        prev = gain;
        mono = 1'b1;
        for (int s = 0; s < 8; s++) begin
            send(0, 0);
            repeat (5) step();
            if (gain < prev) mono = 1'b0;
            prev = gain;
            $display("txn gain_sat step=%0d gain=%0d", s, gain);
        end
        chk("sat_monotonic", mono, 1);
        chk("sat_gain", gain, 262143);

        freeze = 1'b1;
        step();
        send(32767, -32768);
        step();
        step();
        chk("sat_valid", out_vld, 1);
        chk("sat_dataI", out_i, 32767);
        chk("sat_dataQ", out_q, -32768);
        step();
        chk("sat_mag_avg", mag_avg, 65535);
        step();
        chk("sat_gain_frozen", gain, 262143);
        $display("txn sat_output I=%0d Q=%0d mag_avg=%0d gain=%0d", out_i, out_q, mag_avg, gain);

        // Reset with two samples in flight: both are dropped.
        send(111, 222);
        send(333, 444);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_gain", gain, 4096);
        chk("midrst_valid", out_vld, 0);
        chk("midrst_dataI", out_i, 0);
        chk("midrst_mag_avg", mag_avg, 0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_vld) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (5) begin
            step();
            if (out_vld) seen = 1'b1;
        end
        chk("midrst_no_valid", seen, 0);
        send(1234, -4321);
        chk("post_rst_valid_n1", out_vld, 0);
        step();
        chk("post_rst_valid_n2", out_vld, 0);
        step();
        chk("post_rst_valid_n3", out_vld, 1);
        chk("post_rst_dataI", out_i, 1234);
        chk("post_rst_dataQ", out_q, -4321);
        $display("txn post_reset I=%0d Q=%0d valid=%0d", out_i, out_q, out_vld);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
